// File: rtl/axi_sram_slave_rv32_if.sv
// Load/store channel bundle between the LSU and the SRAM responder.
// The slave modport is the responder side; master is the LSU/testbench side.
interface axi_sram_slave_rv32_if #(
    parameter int DATA_LEN     = 32,
    parameter int DATA_BIT_NUM = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [DATA_LEN-1:0]     waddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_BIT_NUM-1:0] wstrob;
    logic [DATA_LEN-1:0]     wdata;
    logic                    bvalid;
    logic                    bready;
    logic [2:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_LEN-1:0]     raddr;
    logic                    rvalid;
    logic                    rready;
    logic [2:0]              rresp;
    logic [DATA_LEN-1:0]     rdata;

    modport slave (
        input  awvalid, waddr, wvalid, wstrob, wdata, bready, arvalid, raddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport master (
        output awvalid, waddr, wvalid, wstrob, wdata, bready, arvalid, raddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_sram_slave_rv32.sv
// Word-addressed SRAM responder with independent read and write FSMs.
// Define AXI_SRAM_RAND_DELAY_EN to insert LFSR-driven response delays.
//
// state     | meaning
// W_IDLE    | waiting for AW and/or W, both readies high
// W_WAIT_W  | address latched, waiting for write data
// W_WAIT_AW | data/strobe latched, waiting for write address
// W_DELAY   | write committed, counting down before bvalid (delay build only)
// W_RESP    | bvalid high until bready
// R_IDLE    | arready high, waiting for read address
// R_DELAY   | read sampled, counting down before rvalid (delay build only)
// R_RESP    | rvalid high until rready
module axi_sram_slave_rv32 #(
    parameter int DATA_LEN     = 32,
    parameter int DATA_BIT_NUM = 4,
    parameter int ADDR_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_sram_slave_rv32_if.slave  bus
);

    localparam logic [2:0] RESP_OK  = 3'b000;
    localparam logic [2:0] RESP_ERR = 3'b010;

`ifdef AXI_SRAM_RAND_DELAY_EN
    typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_DELAY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;
`else
    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_t;
`endif

    logic [DATA_LEN-1:0] mem [2**ADDR_W];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_LEN-1:0]     aw_addr_q;
    logic [DATA_LEN-1:0]     w_data_q;
    logic [DATA_BIT_NUM-1:0] w_strb_q;
    logic [2:0]              bresp_q;
    logic [DATA_LEN-1:0]     rdata_q;
    logic [2:0]              rresp_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    commit_en, latch_aw, latch_w;
    logic [DATA_LEN-1:0]     commit_addr;
    logic [DATA_LEN-1:0]     commit_data;
    logic [DATA_BIT_NUM-1:0] commit_strb;

    function automatic logic addr_in_range(input logic [DATA_LEN-1:0] a);
        return a[DATA_LEN-1:ADDR_W+2] == '0;
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [DATA_LEN-1:0] a);
        return a[ADDR_W+1:2];
    endfunction

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] w_lfsr, r_lfsr, w_lfsr_nxt, r_lfsr_nxt;
    logic [2:0] w_cnt, r_cnt;
    assign w_lfsr_nxt = {w_lfsr[4] ^ w_lfsr[3] ^ w_lfsr[2] ^ w_lfsr[0], w_lfsr[7:1]};
    assign r_lfsr_nxt = {r_lfsr[4] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0], r_lfsr[7:1]};
`endif

    assign bus.awready = (w_state == W_IDLE) || (w_state == W_WAIT_AW);
    assign bus.wready  = (w_state == W_IDLE) || (w_state == W_WAIT_W);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    // Byte-lane offset bits never select anything in a word-addressed array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.raddr[1:0], commit_addr[1:0]};

    always_comb begin
        w_next      = w_state;
        commit_en   = 1'b0;
        latch_aw    = 1'b0;
        latch_w     = 1'b0;
        commit_addr = bus.waddr;
        commit_data = bus.wdata;
        commit_strb = bus.wstrob;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_en = 1'b1;
                end else if (aw_hs) begin
                    latch_aw = 1'b1;
                    w_next   = W_WAIT_W;
                end else if (w_hs) begin
                    latch_w = 1'b1;
                    w_next  = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    commit_en   = 1'b1;
                    commit_addr = aw_addr_q;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    commit_en   = 1'b1;
                    commit_data = w_data_q;
                    commit_strb = w_strb_q;
                end
            end
`ifdef AXI_SRAM_RAND_DELAY_EN
            W_DELAY: begin
                if (w_cnt == 3'd1) w_next = W_RESP;
            end
`endif
            W_RESP: begin
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        if (commit_en) begin
`ifdef AXI_SRAM_RAND_DELAY_EN
            w_next = (w_lfsr_nxt[2:0] == 3'd0) ? W_RESP : W_DELAY;
`else
            w_next = W_RESP;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OK;
`ifdef AXI_SRAM_RAND_DELAY_EN
            w_lfsr    <= 8'h01;
            w_cnt     <= '0;
`endif
        end else begin
            w_state <= w_next;
            if (latch_aw) aw_addr_q <= bus.waddr;
            if (latch_w) begin
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrob;
            end
            if (commit_en) begin
                bresp_q <= addr_in_range(commit_addr) ? RESP_OK : RESP_ERR;
`ifdef AXI_SRAM_RAND_DELAY_EN
                w_lfsr  <= w_lfsr_nxt;
                w_cnt   <= w_lfsr_nxt[2:0];
            end else if (w_state == W_DELAY) begin
                w_cnt   <= w_cnt - 3'd1;
`endif
            end
        end
    end

    // Contents survive reset; the commit is blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && commit_en && addr_in_range(commit_addr)) begin
            for (int i = 0; i < DATA_BIT_NUM; i++) begin
                if (commit_strb[i])
                    mem[word_idx(commit_addr)][8*i +: 8] <= commit_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
`ifdef AXI_SRAM_RAND_DELAY_EN
                    r_next = (r_lfsr_nxt[2:0] == 3'd0) ? R_RESP : R_DELAY;
`else
                    r_next = R_RESP;
`endif
                end
            end
`ifdef AXI_SRAM_RAND_DELAY_EN
            R_DELAY: begin
                if (r_cnt == 3'd1) r_next = R_RESP;
            end
`endif
            R_RESP: begin
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Sampling at the AR edge returns pre-write data on a same-edge collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OK;
`ifdef AXI_SRAM_RAND_DELAY_EN
            r_lfsr  <= 8'h01;
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                if (addr_in_range(bus.raddr)) begin
                    rdata_q <= mem[word_idx(bus.raddr)];
                    rresp_q <= RESP_OK;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_ERR;
                end
`ifdef AXI_SRAM_RAND_DELAY_EN
                r_lfsr <= r_lfsr_nxt;
                r_cnt  <= r_lfsr_nxt[2:0];
            end else if (r_state == R_DELAY) begin
                r_cnt  <= r_cnt - 3'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave_rv32.sv
// Directed bench for axi_sram_slave_rv32 (default build, fixed one-cycle latency).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_sram_slave_rv32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_sram_slave_rv32_if bus ();

    axi_sram_slave_rv32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic bv, output logic [2:0] br);
        bus.awvalid = 1'b1; bus.waddr = a;
        bus.wvalid  = 1'b1; bus.wdata = d; bus.wstrob = s;
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bv = bus.bvalid; br = bus.bresp;
        bus.bready = 1'b1;
        cyc();
        bus.bready = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic rv, output logic [2:0] rr,
                             output logic [31:0] rd);
        bus.arvalid = 1'b1; bus.raddr = a;
        cyc();
        bus.arvalid = 1'b0;
        rv = bus.rvalid; rr = bus.rresp; rd = bus.rdata;
        bus.rready = 1'b1;
        cyc();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL reset_awready got=%0b want=1", bus.awready); end
        n_cmp++; if (bus.wready !== 1'b1) begin n_err++; $display("FAIL reset_wready got=%0b want=1", bus.wready); end
        n_cmp++; if (bus.arready !== 1'b1) begin n_err++; $display("FAIL reset_arready got=%0b want=1", bus.arready); end
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got=%0b want=0", bus.bvalid); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%0b want=0", bus.rvalid); end
        n_cmp++; if (bus.bresp !== 3'b000) begin n_err++; $display("FAIL reset_bresp got=%0h want=0", bus.bresp); end
        n_cmp++; if (bus.rresp !== 3'b000) begin n_err++; $display("FAIL reset_rresp got=%0h want=0", bus.rresp); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%0h want=0", bus.rdata); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic bv, rv; logic [2:0] br, rr; logic [31:0] rd;
        write_word(32'h10, 32'hDEADBEEF, 4'hF, bv, br);
        n_cmp++; if (bv !== 1'b1) begin n_err++; $display("FAIL basic_bvalid got=%0b want=1", bv); end
        n_cmp++; if (br !== 3'b000) begin n_err++; $display("FAIL basic_bresp got=%0h want=0", br); end
        read_word(32'h10, rv, rr, rd);
        n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL basic_rvalid got=%0b want=1", rv); end
        n_cmp++; if (rr !== 3'b000) begin n_err++; $display("FAIL basic_rresp got=%0h want=0", rr); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata got=%0h want=deadbeef", rd); end
    endtask

    task automatic test_strobe();
        logic bv, rv; logic [2:0] br, rr; logic [31:0] rd;
        write_word(32'h14, 32'h11223344, 4'hF, bv, br);
        bus.wvalid = 1'b1; bus.wdata = 32'h00AB0000; bus.wstrob = 4'b0100;
        cyc();
        bus.wvalid = 1'b0; bus.wdata = 32'hFFFFFFFF; bus.wstrob = 4'hF;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL strobe_wready_wait%0d got=%0b want=0", i, bus.wready); end
            n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL strobe_awready_wait%0d got=%0b want=1", i, bus.awready); end
            n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL strobe_bvalid_wait%0d got=%0b want=0", i, bus.bvalid); end
            if (i < 2) cyc();
        end
        bus.awvalid = 1'b1; bus.waddr = 32'h14;
        cyc();
        bus.awvalid = 1'b0;
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL strobe_bvalid got=%0b want=1", bus.bvalid); end
        bus.bready = 1'b1; cyc(); bus.bready = 1'b0;
        read_word(32'h14, rv, rr, rd);
        n_cmp++; if (rd !== 32'h11AB3344) begin n_err++; $display("FAIL strobe_rdata got=%0h want=11ab3344", rd); end
        // address first, then data; zero strobe leaves the word untouched
        bus.awvalid = 1'b1; bus.waddr = 32'h14;
        cyc();
        bus.awvalid = 1'b0;
        n_cmp++; if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin n_err++; $display("FAIL strobe_aw_first got=%0b%0b want=01", bus.awready, bus.wready); end
        bus.wvalid = 1'b1; bus.wdata = 32'h99999999; bus.wstrob = 4'h0;
        cyc();
        bus.wvalid = 1'b0;
        n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 3'b000) begin n_err++; $display("FAIL strobe_zero_b got=%0b/%0h want=1/0", bus.bvalid, bus.bresp); end
        bus.bready = 1'b1; cyc(); bus.bready = 1'b0;
        read_word(32'h14, rv, rr, rd);
        n_cmp++; if (rd !== 32'h11AB3344) begin n_err++; $display("FAIL strobe_zero_rdata got=%0h want=11ab3344", rd); end
    endtask

    task automatic test_out_of_range();
        logic bv, rv; logic [2:0] br, rr; logic [31:0] rd;
        write_word(32'h0, 32'hCAFE0001, 4'hF, bv, br);
        write_word(32'h1000, 32'hFFFFFFFF, 4'hF, bv, br);
        n_cmp++; if (br !== 3'b010) begin n_err++; $display("FAIL oor_bresp got=%0h want=2", br); end
        read_word(32'h1000, rv, rr, rd);
        n_cmp++; if (rr !== 3'b010) begin n_err++; $display("FAIL oor_rresp got=%0h want=2", rr); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_rdata got=%0h want=0", rd); end
        read_word(32'h0, rv, rr, rd);
        n_cmp++; if (rd !== 32'hCAFE0001) begin n_err++; $display("FAIL oor_word0 got=%0h want=cafe0001", rd); end
    endtask

    task automatic test_bready_stall();
        logic rv; logic [2:0] rr; logic [31:0] rd;
        bus.awvalid = 1'b1; bus.waddr = 32'h1004; bus.wvalid = 1'b1; bus.wdata = 32'h1; bus.wstrob = 4'hF;
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 3'b010) begin n_err++; $display("FAIL stall_b%0d got=%0b/%0h want=1/2", i, bus.bvalid, bus.bresp); end
            n_cmp++; if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d got=%0b%0b want=00", i, bus.awready, bus.wready); end
            bus.awvalid = 1'b1; bus.waddr = 32'h34; bus.wvalid = 1'b1; bus.wdata = 32'h12345678;
            cyc();
        end
        bus.bready = 1'b1;
        cyc();
        bus.bready = 1'b0;
        n_cmp++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin n_err++; $display("FAIL stall_release got=%0b%0b%0b want=011", bus.bvalid, bus.awready, bus.wready); end
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 3'b000) begin n_err++; $display("FAIL stall_next_b got=%0b/%0h want=1/0", bus.bvalid, bus.bresp); end
        bus.bready = 1'b1; cyc(); bus.bready = 1'b0;
        read_word(32'h34, rv, rr, rd);
        n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL stall_rdata got=%0h want=12345678", rd); end
    endtask

    task automatic test_same_word();
        logic bv, rv; logic [2:0] br, rr; logic [31:0] rd;
        write_word(32'h20, 32'h77, 4'hF, bv, br);
        bus.arvalid = 1'b1; bus.raddr = 32'h20;
        bus.awvalid = 1'b1; bus.waddr = 32'h20; bus.wvalid = 1'b1; bus.wdata = 32'h55; bus.wstrob = 4'hF;
        cyc();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0) begin n_err++; $display("FAIL same_rv_ar got=%0b%0b want=10", bus.rvalid, bus.arready); end
        n_cmp++; if (bus.rdata !== 32'h77) begin n_err++; $display("FAIL same_rdata_old got=%0h want=77", bus.rdata); end
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL same_bvalid got=%0b want=1", bus.bvalid); end
        bus.rready = 1'b1; bus.bready = 1'b1;
        cyc();
        bus.rready = 1'b0; bus.bready = 1'b0;
        read_word(32'h20, rv, rr, rd);
        n_cmp++; if (rd !== 32'h55) begin n_err++; $display("FAIL same_rdata_new got=%0h want=55", rd); end
    endtask

    task automatic test_reset_mid();
        logic rv; logic [2:0] rr; logic [31:0] rd;
        bus.arvalid = 1'b1; bus.raddr = 32'h10;
        cyc();
        bus.arvalid = 1'b0;
        cyc();
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rstmid_hold got=%0b/%0h want=1/deadbeef", bus.rvalid, bus.rdata); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin n_err++; $display("FAIL rstmid_async got=%0b%0b want=01", bus.rvalid, bus.arready); end
        cyc();
        rst = 1'b0;
        cyc();
        read_word(32'h10, rv, rr, rd);
        n_cmp++; if (rd !== 32'hDEADBEEF || rv !== 1'b1) begin n_err++; $display("FAIL rstmid_retained got=%0b/%0h want=1/deadbeef", rv, rd); end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.waddr = '0; bus.wvalid = 1'b0; bus.wstrob = '0; bus.wdata = '0;
        bus.bready = 1'b0; bus.arvalid = 1'b0; bus.raddr = '0; bus.rready = 1'b0;
        cyc();
        cyc();
        test_reset();
        test_basic();
        test_strobe();
        test_out_of_range();
        test_bready_stall();
        test_same_word();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
